pid_pwm_drive: RTL and testbench
================================

# pid_pwm_drive

Output stage of the gain-scheduled PD controller. It consumes the signed 32-bit controller output and converts it to a single-ended PWM signal plus a direction line for an H-bridge driver. It applies scaling, magnitude saturation, per-period shadowed duty updates and a dead band on every direction reversal. The applied duty is exported for bus readback.

## Interface
- SHIFT, 0: arithmetic right shift applied to PID_OUT_Set before saturation (0..31).
- DEAD_CYCLES, 50: clocks of forced-off output on a direction reversal; 0 disables the dead band.
- CLK  in  1  system clock; all logic on posedge.
- RST_n  in  1  reset, asynchronous, active-low.
- PID_OUT_Set  in  32  signed controller command, two's complement.
- PWM_PERIOD_Set  in  32  unsigned PWM period in clocks.
- PWM_MAX_Set  in  32  unsigned duty ceiling in clocks.
- DRV_EN  in  1  output enable; low forces PWM_OUT to 0.
- PWM_OUT  out  1  registered PWM drive.
- DIR_OUT  out  1  registered direction: 1 for negative command, 0 for positive.
- DUTY_REG  out  32  duty in clocks currently being applied.
- SAT_FLAG  out  1  high while the applied duty came from a clamped command.

## Operation
- Counter cnt runs 0..per_eff-1 and wraps. The last cycle, cnt==per_eff-1, is the boundary.
- At each boundary, all inputs are sampled and shadowed in one step, so no mid-period duty change is possible:
  - per_eff = max(PWM_PERIOD_Set, 2).
  - s = PID_OUT_Set >>> SHIFT (signed).
  - mag = |s| in 33-bit arithmetic, so -2^31 gives 2^31 with no overflow.
  - lim = min(PWM_MAX_Set, per_eff).
  - duty = min(mag, lim).
  - SAT_FLAG = (mag > lim).
  - ndir = (s<0). When s==0, ndir equals the current DIR_OUT.
- State RUN:
  - PWM_OUT is high for the first DUTY_REG cycles of each period and low for the rest.
  - duty ≥ per_eff gives a constant high output.
- RUN to DEAD: taken at a boundary when ndir != DIR_OUT, duty != 0 and DEAD_CYCLES != 0.
  - DUTY_REG and SAT_FLAG take their new values.
  - DIR_OUT is unchanged.
- State DEAD:
  - PWM_OUT=0 and cnt is held at 0.
  - A dead counter runs DEAD_CYCLES clocks. On its final clock, DIR_OUT <= ndir and the FSM returns to RUN.
  - A new period starts on the next clock.
  - Inputs are ignored while in DEAD.
- Reversal with DEAD_CYCLES==0: DIR_OUT switches at the boundary and the new period starts immediately.
- Reversal with duty==0: there is no dead band and DIR_OUT does not change.
- DRV_EN low:
  - PWM_OUT is 0 from the next clock.
  - Counter, shadow loads and the FSM keep running.
  - When DRV_EN returns high, output resumes mid-period from the current cnt.
- Reset, including mid-DEAD:
  - cnt=0, per_eff=2, state RUN.
  - PWM_OUT=0, DIR_OUT=0, DUTY_REG=0, SAT_FLAG=0.

## Timing
- PWM_OUT, DIR_OUT, DUTY_REG and SAT_FLAG are registers with no combinational path from the inputs.
- Command latency: a value present at boundary edge k appears on DUTY_REG after edge k. It drives PWM_OUT from the first cycle of the next period.
- Worst case from an input change to its effect is per_eff+1 clocks, plus DEAD_CYCLES on a reversal.
- Period length is exactly per_eff clocks. The high pulse is exactly DUTY_REG clocks, beginning on the first cycle of the period.
- A dead band inserts exactly DEAD_CYCLES low cycles between the last cycle of the old period and the first cycle of the new one.
- PWM_PERIOD_Set may change at any time. It takes effect only at a boundary, and the new period starts immediately after that boundary.
- No handshake is used. Inputs are quasi-static register contents and must be stable in the boundary cycle.

## Test plan
- Nominal command: PERIOD=100, MAX=100, SHIFT=0, PID_OUT=+30, DRV_EN=1 -> after the first full period, PWM_OUT is 30 high / 70 low repeating, DIR_OUT=0, SAT_FLAG=0.
- Saturation: PID_OUT=+500, MAX=80, PERIOD=100 -> DUTY_REG=80, SAT_FLAG=1. Then PID_OUT=-2^31 -> DUTY_REG=80, DIR reversal occurs, no wrap to 0.
- Reversal: +30 then -40 with DEAD_CYCLES=50 -> exactly 50 low cycles after the boundary, DIR_OUT 0->1, then a 40-high period; DUTY_REG=40 during the dead band.
- Zero command: +30, then 0, then +30 -> DUTY_REG=0 with PWM_OUT low for a full period, DIR_OUT stays 0 throughout, no dead band.
- Enable and scaling: PERIOD=1 -> period of 2. SHIFT=4 with PID_OUT=-160 -> duty 10 clamped to 2 with SAT_FLAG=1. DRV_EN toggled mid-period -> PWM_OUT is 0 the next clock and cnt is undisturbed.
- Reset mid-DEAD: assert RST_n low 10 cycles into the dead band -> all outputs 0 asynchronously. After release, the first period is 2 clocks, then the programmed period resumes.

Source files
------------

// File: rtl/pid_pwm_drive.sv
// Output stage of the PD controller: signed command -> shadowed PWM duty plus H-bridge direction.
// All command/period state reloads only at the period boundary; direction reversals insert a dead band.
module pid_pwm_drive #(
    parameter int SHIFT       = 0,
    parameter int DEAD_CYCLES = 50
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic [31:0] PID_OUT_Set,
    input  logic [31:0] PWM_PERIOD_Set,
    input  logic [31:0] PWM_MAX_Set,
    input  logic        DRV_EN,
    output logic        PWM_OUT,
    output logic        DIR_OUT,
    output logic [31:0] DUTY_REG,
    output logic        SAT_FLAG
);
    typedef enum logic {RUN, DEAD} state_t;

    localparam logic [31:0] DEAD_LAST = 32'(DEAD_CYCLES - 1);

    state_t             r_state, w_state_nxt;
    logic [31:0]        r_cnt, r_per, r_dcnt, r_duty;
    logic               r_pwm, r_dir, r_sat, r_ndir;
    logic signed [31:0] w_s;
    logic [32:0]        w_mag;
    logic [31:0]        w_per_new, w_lim, w_duty_new;
    logic               w_sat_new, w_ndir, w_bnd;
    logic [31:0]        w_cnt_nxt, w_per_nxt, w_dcnt_nxt, w_duty_nxt;
    logic               w_dir_nxt, w_sat_nxt, w_ndir_nxt, w_pwm_nxt;

    // 33-bit magnitude so the most negative command cannot wrap to zero
    assign w_s        = $signed(PID_OUT_Set) >>> SHIFT;
    assign w_mag      = w_s[31] ? (33'd0 - {w_s[31], w_s}) : {1'b0, w_s};
    assign w_per_new  = (PWM_PERIOD_Set < 32'd2) ? 32'd2 : PWM_PERIOD_Set;
    assign w_lim      = (PWM_MAX_Set < w_per_new) ? PWM_MAX_Set : w_per_new;
    assign w_sat_new  = w_mag > {1'b0, w_lim};
    assign w_duty_new = w_sat_new ? w_lim : w_mag[31:0];
    assign w_ndir     = (w_s == 32'sd0) ? r_dir : w_s[31];
    assign w_bnd      = (r_cnt == r_per - 32'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_per_nxt   = r_per;
        w_dcnt_nxt  = r_dcnt;
        w_duty_nxt  = r_duty;
        w_dir_nxt   = r_dir;
        w_sat_nxt   = r_sat;
        w_ndir_nxt  = r_ndir;
        case (r_state)
            RUN: begin
                if (w_bnd) begin
                    w_cnt_nxt  = 32'd0;
                    w_per_nxt  = w_per_new;
                    w_duty_nxt = w_duty_new;
                    w_sat_nxt  = w_sat_new;
                    w_ndir_nxt = w_ndir;
                    if ((w_ndir != r_dir) && (w_duty_new != 32'd0)) begin
                        if (DEAD_CYCLES != 0) begin
                            w_state_nxt = DEAD;
                            w_dcnt_nxt  = 32'd0;
                        end else begin
                            w_dir_nxt = w_ndir;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            DEAD: begin
                // cnt stays at 0, so the new period begins right after the last dead clock
                if (r_dcnt == DEAD_LAST) begin
                    w_state_nxt = RUN;
                    w_dir_nxt   = r_ndir;
                end else begin
                    w_dcnt_nxt = r_dcnt + 32'd1;
                end
            end
            default: w_state_nxt = RUN;
        endcase
        // output is registered against the next cycle's counter so it aligns with cnt
        w_pwm_nxt = DRV_EN && (w_state_nxt == RUN) && (w_cnt_nxt < w_duty_nxt);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= RUN;
            r_cnt   <= 32'd0;
            r_per   <= 32'd2;
            r_dcnt  <= 32'd0;
            r_duty  <= 32'd0;
            r_dir   <= 1'b0;
            r_sat   <= 1'b0;
            r_ndir  <= 1'b0;
            r_pwm   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_per   <= w_per_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_duty  <= w_duty_nxt;
            r_dir   <= w_dir_nxt;
            r_sat   <= w_sat_nxt;
            r_ndir  <= w_ndir_nxt;
            r_pwm   <= w_pwm_nxt;
        end
    end

    assign PWM_OUT  = r_pwm;
    assign DIR_OUT  = r_dir;
    assign DUTY_REG = r_duty;
    assign SAT_FLAG = r_sat;
endmodule

// File: tb/tb_pid_pwm_drive.sv
// Bench for pid_pwm_drive: two instances (SHIFT=0/DEAD=50 and SHIFT=4/DEAD=0) against a
// waveform model that expands each sampled period into a queue of expected cycles.
module tb_pid_pwm_drive;
    typedef struct packed {
        logic        pwm;
        logic        dir;
        logic [31:0] duty;
        logic        sat;
        logic        dead;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic [31:0] PID_OUT_Set, PWM_PERIOD_Set, PWM_MAX_Set;
    logic        DRV_EN;
    logic        pwm [2];
    logic        dir [2];
    logic        sat [2];
    logic [31:0] duty [2];

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   dcnt  = 0;
    bit   arm_rst = 1'b0;

    always #5 CLK = ~CLK;

    pid_pwm_drive #(.SHIFT(0), .DEAD_CYCLES(50)) u_dut0 (
        .CLK(CLK), .RST_n(RST_n), .PID_OUT_Set(PID_OUT_Set), .PWM_PERIOD_Set(PWM_PERIOD_Set),
        .PWM_MAX_Set(PWM_MAX_Set), .DRV_EN(DRV_EN), .PWM_OUT(pwm[0]), .DIR_OUT(dir[0]),
        .DUTY_REG(duty[0]), .SAT_FLAG(sat[0]));

    pid_pwm_drive #(.SHIFT(4), .DEAD_CYCLES(0)) u_dut1 (
        .CLK(CLK), .RST_n(RST_n), .PID_OUT_Set(PID_OUT_Set), .PWM_PERIOD_Set(PWM_PERIOD_Set),
        .PWM_MAX_Set(PWM_MAX_Set), .DRV_EN(DRV_EN), .PWM_OUT(pwm[1]), .DIR_OUT(dir[1]),
        .DUTY_REG(duty[1]), .SAT_FLAG(sat[1]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic exp_t qfront(input int k);
        return (k == 0) ? qa[0] : qb[0];
    endfunction

    function automatic exp_t qlast(input int k);
        return (k == 0) ? qa[$] : qb[$];
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? qa.size() : qb.size();
    endfunction

    task automatic qpush(input int k, input exp_t e);
        if (k == 0) qa.push_back(e); else qb.push_back(e);
    endtask

    task automatic qpop(input int k);
        if (k == 0) void'(qa.pop_front()); else void'(qb.pop_front());
    endtask

    // After reset the current cycle and one more form the fixed 2-clock period at zero duty
    task automatic qreset(input int k);
        exp_t z;
        z = '0;
        if (k == 0) qa.delete(); else qb.delete();
        qpush(k, z);
        qpush(k, z);
    endtask

    // Expand one period (plus any dead band) from the inputs the DUT samples at the boundary
    task automatic build(input int k);
        longint per, mx, cmd, s, mag, lim, dty;
        bit     ndir, odir, st;
        int     dc;
        exp_t   e;
        odir = qlast(k).dir;
        per  = longint'(PWM_PERIOD_Set);
        if (per < 2) per = 2;
        mx   = longint'(PWM_MAX_Set);
        cmd  = longint'($signed(PID_OUT_Set));
        s    = cmd >>> ((k == 0) ? 0 : 4);
        mag  = (s < 0) ? -s : s;
        lim  = (mx < per) ? mx : per;
        dty  = (mag < lim) ? mag : lim;
        st   = (mag > lim);
        ndir = (s < 0) ? 1'b1 : ((s > 0) ? 1'b0 : odir);
        dc   = (k == 0) ? 50 : 0;
        if ((ndir != odir) && (dty != 0)) begin
            for (int i = 0; i < dc; i++) begin
                e.pwm = 1'b0; e.dir = odir; e.duty = dty[31:0]; e.sat = st; e.dead = 1'b1;
                qpush(k, e);
            end
            odir = ndir;
        end
        for (longint i = 0; i < per; i++) begin
            e.pwm = (i < dty); e.dir = odir; e.duty = dty[31:0]; e.sat = st; e.dead = 1'b0;
            qpush(k, e);
        end
    endtask

    task automatic chk_cur(input int k);
        exp_t e;
        e = qfront(k);
        check($sformatf("pwm%0d", k), 64'(pwm[k]), 64'(e.pwm & DRV_EN));
        check($sformatf("dir%0d", k), 64'(dir[k]), 64'(e.dir));
        check($sformatf("duty%0d", k), 64'(duty[k]), 64'(e.duty));
        check($sformatf("sat%0d", k), 64'(sat[k]), 64'(e.sat));
        if (k == 0) dcnt = e.dead ? dcnt + 1 : 0;
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 2; k++)
            check($sformatf("%s%0d", tag, k), {pwm[k], dir[k], sat[k], duty[k]}, 64'd0);
    endtask

    function automatic logic [31:0] pick_cmd();
        int v;
        case ($urandom_range(0, 5))
            0: begin v = int'($urandom_range(0, 120)) - 60; return 32'(v); end
            1: return 32'd0;
            2: return 32'h8000_0000;
            3: return 32'h7fff_ffff;
            4: begin v = int'($urandom_range(0, 1600)) - 800; return 32'(v); end
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_inputs();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 3)       PID_OUT_Set    = pick_cmd();
        else if (r < 5)  PWM_PERIOD_Set = $urandom_range(0, 40);
        else if (r < 7)  PWM_MAX_Set    = $urandom_range(0, 50);
        else if (r < 10) DRV_EN         = ~DRV_EN;
    endtask

    // Invariant between iterations: q[0] is the current cycle and has been checked
    task automatic run(input int n, input bit rnd);
        for (int c = 0; c < n; c++) begin
            if (rnd) rand_inputs();
            for (int k = 0; k < 2; k++) begin
                if (qsize(k) == 1) build(k);
                qpop(k);
            end
            @(negedge CLK);
            chk_cur(0);
            chk_cur(1);
            if (arm_rst && dcnt == 10) begin
                arm_rst = 1'b0;
                dcnt    = 0;
                RST_n   = 1'b0;
                #1;
                chk_zero("rst_async");
                qreset(0);
                qreset(1);
                repeat (3) begin
                    @(negedge CLK);
                    chk_zero("rst_hold");
                end
                RST_n = 1'b1;
            end
        end
    endtask

    initial begin
        RST_n          = 1'b0;
        PID_OUT_Set    = 32'd30;
        PWM_PERIOD_Set = 32'd100;
        PWM_MAX_Set    = 32'd100;
        DRV_EN         = 1'b1;
        qreset(0);
        qreset(1);
        repeat (3) @(negedge CLK);
        chk_zero("reset");
        RST_n = 1'b1;

        run(250, 1'b0);                                   // nominal +30
        PID_OUT_Set = 32'd0;          run(250, 1'b0);     // zero command, no reversal
        PID_OUT_Set = 32'd30;         run(250, 1'b0);
        PID_OUT_Set = 32'd500; PWM_MAX_Set = 32'd80; run(250, 1'b0);
        PID_OUT_Set = 32'h8000_0000;  run(300, 1'b0);     // clamp, reversal
        PID_OUT_Set = 32'd30; PWM_MAX_Set = 32'd100; run(320, 1'b0);
        PID_OUT_Set = 32'(-40); arm_rst = 1'b1; run(320, 1'b0);
        check("rst_fired", 64'(arm_rst), 64'd0);
        run(200, 1'b0);
        PWM_PERIOD_Set = 32'd1; PID_OUT_Set = 32'(-160); run(9, 1'b0);
        DRV_EN = 1'b0; run(3, 1'b0);
        DRV_EN = 1'b1; run(20, 1'b0);
        PWM_PERIOD_Set = 32'd20; PWM_MAX_Set = 32'd0; PID_OUT_Set = 32'd30; run(60, 1'b0);
        PID_OUT_Set = 32'(-30); run(60, 1'b0);            // reversal at zero duty
        PWM_PERIOD_Set = 32'd15; PWM_MAX_Set = 32'd12; PID_OUT_Set = 32'd7; run(40, 1'b0);
        DRV_EN = 1'b0; run(5, 1'b0);
        DRV_EN = 1'b1; run(40, 1'b0);
        PWM_MAX_Set = 32'd50;
        run(4000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
